axi_rd_data_engine: RTL and testbench
=====================================

# axi_rd_data_engine

Parametrised AXI4 slave read-data engine for the slave memory model. Accepts decoded read bursts from the read-address stage into a command FIFO and fetches one memory word per beat over a synchronous word-wide memory port. Drives the R channel with correct lane placement for FIXED, INCR and WRAP bursts, narrow and unaligned transfers, RREADY backpressure, and SLVERR/DECERR responses.

## Interface
- AXI_DW, 256: R data width in bits; must be a power of two, at least 32.
- AXI_IW, 4: ID width.
- AXI_AW, 32: address width.
- AXI_SW, AXI_DW/8: byte lanes.
- CMD_DEPTH, 4: command FIFO entries (power of two, at least 2).
- MEM_AW, 12: memory byte-address bits. Word address width is WW = MEM_AW − log2(AXI_SW).

- axi_clk_i, in, 1: clock.
- axi_rst_i, in, 1: synchronous, active-high reset.
- cmd_valid_i / cmd_ready_o, in/out, 1: command handshake.
- cmd_id_i, in, AXI_IW: burst ID.
- cmd_addr_i, in, AXI_AW: start address.
- cmd_len_i, in, 8: beats − 1.
- cmd_size_i, in, 3: log2 bytes per beat.
- cmd_burst_i, in, 2: burst type (00 FIXED, 01 INCR, 10 WRAP).
- mem_ren_o, out, 1: memory read strobe.
- mem_addr_o, out, WW: word address.
- mem_rdata_i, in, AXI_DW: read data, valid in the cycle after mem_ren_o.
- axi_rid_o, out, AXI_IW; axi_rdata_o, out, AXI_DW; axi_rstrb_o, out, AXI_SW; axi_rresp_o, out, 2; axi_rlast_o, out, 1; axi_ruser_o, out, 4 (tied 0); axi_rvalid_o, out, 1.
- axi_rready_i, in, 1.

## Operation
- Command FIFO:
  - cmd_ready_o = !full.
  - A simultaneous push and pop while full is not permitted, because ready is already low.
- FSM states: IDLE, RD, WAIT, DATA.
  - IDLE: if the FIFO is non-empty, pop it, load the burst registers (id, addr, len, size, burst, beat counter = 0, error code), and go to RD.
  - RD: mem_ren_o = 1 and mem_addr_o = beat_addr[MEM_AW−1:log2 SW]. The strobe is suppressed when the error code ≠ OKAY. Next state is WAIT.
  - WAIT: capture mem_rdata_i, masked to the active lanes (inactive lanes = 0), into axi_rdata_o. Set axi_rvalid_o = 1, axi_rlast_o = (beat == len), and load axi_rstrb_o and axi_rresp_o. Next state is DATA.
  - DATA: hold every R output stable while rvalid && !rready. On handshake:
    - if not last: advance the address, increment the beat counter, go to RD.
    - if last: go to IDLE.
- Lane rules (bytes = 1<<size, aligned = addr & ~(bytes−1)):
  - First lane = beat_addr mod SW.
  - Last lane = (aligned + bytes − 1) mod SW.
  - axi_rstrb_o has ones on lanes first..last inclusive.
- Address update:
  - FIXED: address unchanged.
  - INCR: next = aligned + bytes. Only the first beat may be unaligned.
  - WRAP: W = (len+1)·bytes, lower = addr & ~(W−1), next = lower + ((aligned + bytes − lower) mod W).
  - INCR addresses wrap modulo 2^MEM_AW; there is no 4 KB check.
- Errors, decided at pop:
  - SLVERR (10) for any of: burst = 11; size > log2 SW; WRAP with len ∉ {1,3,7,15}; WRAP with an unaligned addr.
  - DECERR (11) when addr ≥ 2^MEM_AW. DECERR takes precedence over SLVERR.
  - An errored burst still returns len+1 beats with rdata = 0, rstrb = 0 and correct rlast, and never asserts mem_ren_o.
- axi_rid_o = burst ID for every beat of the burst.

## Timing
- Reset values: every output is 0 (rid, rdata, rstrb, rresp, rlast, ruser, rvalid, mem_ren_o, mem_addr_o). cmd_ready_o = 1 from the cycle after reset. The FIFO is empty and the FSM is in IDLE.
- Reset during a burst aborts it: outputs return to 0 at the next edge, no rlast is issued, and FIFO contents are discarded.
- Command latency: with the command accepted at edge E0, mem_ren_o is high in the cycle after E1 and axi_rvalid_o is high after E3.
- Beat gap: after a non-last handshake, axi_rvalid_o is low for exactly 2 cycles (RD, WAIT).
- Back-to-back bursts: after a last handshake, the next queued burst's first beat is valid 3 cycles later (IDLE, RD, WAIT).
- Commands may be accepted in any state, including during DATA of a burst.
- rvalid never deasserts without a handshake. rlast is high only together with rvalid.

## Test plan
Configuration for all scenarios: AXI_DW = 32, MEM_AW = 12, memory preloaded with byte[k] = k[7:0].

1. INCR, 0x10, len 3, size 2, rready = 1 → rdata 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C; rstrb 1111; rlast on beat 4; rresp 00.
2. WRAP, 0x38, len 3, size 2 → 0x3B3A3938, 0x3F3E3D3C, 0x33323130, 0x37363534.
3. Narrow and unaligned:
   - FIXED, 0x21, size 0, len 2 → 3 beats of 0x00002100, rstrb 0010.
   - INCR, 0x22, size 2, len 1 → 0x23220000 (strb 1100), then 0x27262524 (strb 1111).
4. Errors:
   - Address 0x1000, len 1 → 2 beats, rresp 11, rdata 0, mem_ren_o never high.
   - WRAP with len 2 → 3 beats, rresp 10.
5. Backpressure and FIFO:
   - Hold rready low for 5 cycles in beat 2 → R outputs stable throughout, no beat lost.
   - Push 5 commands with rready = 0 → cmd_ready_o low after 4 are queued (one popped, CMD_DEPTH = 4 held).
6. Assert axi_rst_i for 1 cycle during beat 2 of an 8-beat burst → all outputs 0 the next cycle, no rlast. A subsequent command completes normally.

Source files
------------

// File: rtl/axi_rd_data_engine.sv
// AXI4 slave read-data engine: queues decoded read bursts, fetches one memory
// word per beat and presents it on the R channel with per-beat lane placement.
module axi_rd_data_engine #(
    parameter  int unsigned AXI_DW    = 256,
    parameter  int unsigned AXI_IW    = 4,
    parameter  int unsigned AXI_AW    = 32,
    parameter  int unsigned AXI_SW    = AXI_DW / 8,
    parameter  int unsigned CMD_DEPTH = 4,
    parameter  int unsigned MEM_AW    = 12,
    localparam int unsigned SB        = $clog2(AXI_SW),
    localparam int unsigned WW        = MEM_AW - SB
) (
    input  logic              axi_clk_i,
    input  logic              axi_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [AXI_IW-1:0] cmd_id_i,
    input  logic [AXI_AW-1:0] cmd_addr_i,
    input  logic [7:0]        cmd_len_i,
    input  logic [2:0]        cmd_size_i,
    input  logic [1:0]        cmd_burst_i,
    output logic              mem_ren_o,
    output logic [WW-1:0]     mem_addr_o,
    input  logic [AXI_DW-1:0] mem_rdata_i,
    output logic [AXI_IW-1:0] axi_rid_o,
    output logic [AXI_DW-1:0] axi_rdata_o,
    output logic [AXI_SW-1:0] axi_rstrb_o,
    output logic [1:0]        axi_rresp_o,
    output logic              axi_rlast_o,
    output logic [3:0]        axi_ruser_o,
    output logic              axi_rvalid_o,
    input  logic              axi_rready_i
);

    localparam int unsigned PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [AXI_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_DATA} state_t;

    cmd_t              fifo_q [CMD_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    state_t            state_q;

    logic [AXI_IW-1:0] id_q;
    logic [MEM_AW-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [1:0]        err_q;

    cmd_t              cmd_in_c;
    cmd_t              head_c;
    logic              push_c;
    logic              pop_c;
    logic [CW-1:0]     count_next_c;
    logic [1:0]        err_c;
    logic [AXI_AW-1:0] head_mask_c;

    logic [MEM_AW-1:0] bytes_c;
    logic [MEM_AW-1:0] aligned_c;
    logic [MEM_AW-1:0] wrap_mask_c;
    logic [MEM_AW-1:0] lower_c;
    logic [MEM_AW-1:0] next_addr_c;
    logic [SB-1:0]     first_lane_c;
    logic [SB-1:0]     last_lane_c;
    logic [AXI_SW-1:0] strb_c;
    logic [AXI_DW-1:0] lane_mask_c;

    assign axi_ruser_o = 4'b0000;

    // FIFO handshake and occupancy bookkeeping
    always_comb begin
        cmd_in_c.id    = cmd_id_i;
        cmd_in_c.addr  = cmd_addr_i;
        cmd_in_c.len   = cmd_len_i;
        cmd_in_c.size  = cmd_size_i;
        cmd_in_c.burst = cmd_burst_i;
        head_c         = fifo_q[rd_ptr_q];
        push_c         = cmd_valid_i && cmd_ready_o;
        pop_c          = (state_q == S_IDLE) && (count_q != '0);
        count_next_c   = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Response code for the burst at the FIFO head; DECERR overrides SLVERR
    always_comb begin
        err_c       = RESP_OKAY;
        head_mask_c = (AXI_AW'(1) << head_c.size) - AXI_AW'(1);
        if ((head_c.burst == BURST_RSVD) ||
            (head_c.size > 3'(SB)) ||
            ((head_c.burst == BURST_WRAP) && !(head_c.len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
            ((head_c.burst == BURST_WRAP) && ((head_c.addr & head_mask_c) != '0))) begin
            err_c = RESP_SLVERR;
        end
        if ((head_c.addr >> MEM_AW) != '0) begin
            err_c = RESP_DECERR;
        end
    end

    // Lane placement for the current beat and address of the following beat
    always_comb begin
        bytes_c      = MEM_AW'(1) << size_q;
        aligned_c    = addr_q & ~(bytes_c - MEM_AW'(1));
        wrap_mask_c  = ((MEM_AW'(len_q) + MEM_AW'(1)) << size_q) - MEM_AW'(1);
        lower_c      = addr_q & ~wrap_mask_c;
        first_lane_c = addr_q[SB-1:0];
        last_lane_c  = SB'(aligned_c + bytes_c - MEM_AW'(1));
        case (burst_q)
            BURST_FIXED: next_addr_c = addr_q;
            BURST_WRAP:  next_addr_c = lower_c + ((aligned_c + bytes_c - lower_c) & wrap_mask_c);
            default:     next_addr_c = aligned_c + bytes_c;
        endcase
        for (int unsigned i = 0; i < AXI_SW; i++) begin
            strb_c[i]             = (SB'(i) >= first_lane_c) && (SB'(i) <= last_lane_c);
            lane_mask_c[8*i +: 8] = {8{strb_c[i]}};
        end
    end

    // Command FIFO, burst sequencer and registered R/memory outputs
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cmd_ready_o  <= 1'b1;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            err_q        <= RESP_OKAY;
            mem_ren_o    <= 1'b0;
            mem_addr_o   <= '0;
            axi_rid_o    <= '0;
            axi_rdata_o  <= '0;
            axi_rstrb_o  <= '0;
            axi_rresp_o  <= '0;
            axi_rlast_o  <= 1'b0;
            axi_rvalid_o <= 1'b0;
        end else begin
            if (push_c) begin
                fifo_q[wr_ptr_q] <= cmd_in_c;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_next_c;
            cmd_ready_o <= (count_next_c != CW'(CMD_DEPTH));
            mem_ren_o   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        id_q       <= head_c.id;
                        addr_q     <= head_c.addr[MEM_AW-1:0];
                        len_q      <= head_c.len;
                        size_q     <= head_c.size;
                        burst_q    <= head_c.burst;
                        beat_q     <= '0;
                        err_q      <= err_c;
                        mem_ren_o  <= (err_c == RESP_OKAY);
                        mem_addr_o <= head_c.addr[MEM_AW-1:SB];
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    axi_rid_o    <= id_q;
                    axi_rdata_o  <= (err_q == RESP_OKAY) ? (mem_rdata_i & lane_mask_c) : '0;
                    axi_rstrb_o  <= (err_q == RESP_OKAY) ? strb_c : '0;
                    axi_rresp_o  <= err_q;
                    axi_rlast_o  <= (beat_q == len_q);
                    axi_rvalid_o <= 1'b1;
                    state_q      <= S_DATA;
                end
                S_DATA: begin
                    if (axi_rready_i) begin
                        axi_rvalid_o <= 1'b0;
                        axi_rlast_o  <= 1'b0;
                        if (beat_q == len_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            addr_q     <= next_addr_c;
                            beat_q     <= beat_q + 8'd1;
                            mem_ren_o  <= (err_q == RESP_OKAY);
                            mem_addr_o <= next_addr_c[MEM_AW-1:SB];
                            state_q    <= S_RD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_data_engine.sv
// Directed bench for axi_rd_data_engine (32-bit data, 4 KB byte-pattern memory).
module tb_axi_rd_data_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned MAW = 12;
    localparam int unsigned WW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_id = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [1:0]    cmd_burst = '0;
    logic          mem_ren;
    logic [WW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [SW-1:0] rstrb;
    logic [1:0]    rresp;
    logic          rlast;
    logic [3:0]    ruser;
    logic          rvalid;
    logic          rready = 1'b1;

    int n_total = 0;
    int n_pass  = 0;
    int ren_count = 0;

    axi_rd_data_engine #(
        .AXI_DW(DW), .AXI_IW(IW), .AXI_AW(AW), .AXI_SW(SW), .CMD_DEPTH(4), .MEM_AW(MAW)
    ) dut (
        .axi_clk_i(clk), .axi_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .cmd_size_i(cmd_size), .cmd_burst_i(cmd_burst),
        .mem_ren_o(mem_ren), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rstrb_o(rstrb), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_ruser_o(ruser), .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: byte[k] = k[7:0]
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= {mem_addr[5:0], 2'b11, mem_addr[5:0], 2'b10,
                          mem_addr[5:0], 2'b01, mem_addr[5:0], 2'b00};
            ren_count <= ren_count + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_cmd(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr;
        cmd_len = len; cmd_size = size; cmd_burst = burst;
        while (!cmd_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic recv_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp, input logic last,
                             input int exp_wait);
        int n = 0;
        while (!rvalid && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
        if (exp_wait >= 0) chk({tag, " gap"}, 32'(n), 32'(exp_wait));
        chk({tag, " rid"},   32'(rid),   32'(id));
        chk({tag, " rdata"}, rdata,      data);
        chk({tag, " rstrb"}, 32'(rstrb), 32'(strb));
        chk({tag, " rresp"}, 32'(rresp), 32'(resp));
        chk({tag, " rlast"}, 32'(rlast), 32'(last));
        @(posedge clk); #1;
    endtask

    initial begin
        int ren_before;
        int seen;
        logic [31:0] exp_pat [5];
        exp_pat[0] = 32'h63626160; exp_pat[1] = 32'h67666564; exp_pat[2] = 32'h6B6A6968;
        exp_pat[3] = 32'h6F6E6D6C; exp_pat[4] = 32'h73727170;

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst rvalid", 32'(rvalid), 32'd0);
        chk("rst rlast",  32'(rlast),  32'd0);
        chk("rst rdata",  rdata,       32'd0);
        chk("rst rstrb",  32'(rstrb),  32'd0);
        chk("rst rresp",  32'(rresp),  32'd0);
        chk("rst rid",    32'(rid),    32'd0);
        chk("rst ruser",  32'(ruser),  32'd0);
        chk("rst mem_ren", 32'(mem_ren), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);

        // 1+2: INCR then WRAP queued back to back
        push_cmd("t1", 4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
        push_cmd("t2", 4'd2, 32'h38, 8'd3, 3'd2, 2'b10);
        chk("t1 mem_ren", 32'(mem_ren), 32'd1);
        chk("t1 mem_addr", 32'(mem_addr), 32'h4);
        recv_beat("t1 b0", 4'd1, 32'h13121110, 4'hF, 2'b00, 1'b0, 2);
        recv_beat("t1 b1", 4'd1, 32'h17161514, 4'hF, 2'b00, 1'b0, 2);
        recv_beat("t1 b2", 4'd1, 32'h1B1A1918, 4'hF, 2'b00, 1'b0, 2);
        recv_beat("t1 b3", 4'd1, 32'h1F1E1D1C, 4'hF, 2'b00, 1'b1, 2);
        recv_beat("t2 b0", 4'd2, 32'h3B3A3938, 4'hF, 2'b00, 1'b0, 3);
        recv_beat("t2 b1", 4'd2, 32'h3F3E3D3C, 4'hF, 2'b00, 1'b0, 2);
        recv_beat("t2 b2", 4'd2, 32'h33323130, 4'hF, 2'b00, 1'b0, 2);
        recv_beat("t2 b3", 4'd2, 32'h37363534, 4'hF, 2'b00, 1'b1, 2);

        // 3: narrow FIXED and unaligned INCR
        push_cmd("t3a", 4'd3, 32'h21, 8'd2, 3'd0, 2'b00);
        recv_beat("t3a b0", 4'd3, 32'h00002100, 4'b0010, 2'b00, 1'b0, -1);
        recv_beat("t3a b1", 4'd3, 32'h00002100, 4'b0010, 2'b00, 1'b0, 2);
        recv_beat("t3a b2", 4'd3, 32'h00002100, 4'b0010, 2'b00, 1'b1, 2);
        push_cmd("t3b", 4'd4, 32'h22, 8'd1, 3'd2, 2'b01);
        recv_beat("t3b b0", 4'd4, 32'h23220000, 4'b1100, 2'b00, 1'b0, -1);
        recv_beat("t3b b1", 4'd4, 32'h27262524, 4'b1111, 2'b00, 1'b1, 2);

        // 4: DECERR and SLVERR bursts never touch memory
        ren_before = ren_count;
        push_cmd("t4a", 4'd5, 32'h1000, 8'd1, 3'd2, 2'b01);
        recv_beat("t4a b0", 4'd5, 32'h0, 4'h0, 2'b11, 1'b0, -1);
        recv_beat("t4a b1", 4'd5, 32'h0, 4'h0, 2'b11, 1'b1, 2);
        push_cmd("t4b", 4'd6, 32'h40, 8'd2, 3'd2, 2'b10);
        recv_beat("t4b b0", 4'd6, 32'h0, 4'h0, 2'b10, 1'b0, -1);
        recv_beat("t4b b1", 4'd6, 32'h0, 4'h0, 2'b10, 1'b0, 2);
        recv_beat("t4b b2", 4'd6, 32'h0, 4'h0, 2'b10, 1'b1, 2);
        chk("t4 mem_ren count", 32'(ren_count - ren_before), 32'd0);

        // 5a: RREADY held low for 5 cycles on beat 2
        push_cmd("t5a", 4'd7, 32'h50, 8'd3, 3'd2, 2'b01);
        recv_beat("t5a b0", 4'd7, 32'h53525150, 4'hF, 2'b00, 1'b0, -1);
        rready = 1'b0;
        seen = 0;
        while (!rvalid && seen < 60) begin
            @(posedge clk); #1; seen++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("t5a hold rvalid", 32'(rvalid), 32'd1);
            chk("t5a hold rdata", rdata, 32'h57565554);
            chk("t5a hold rlast", 32'(rlast), 32'd0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        recv_beat("t5a b1", 4'd7, 32'h57565554, 4'hF, 2'b00, 1'b0, 0);
        recv_beat("t5a b2", 4'd7, 32'h5B5A5958, 4'hF, 2'b00, 1'b0, 2);
        recv_beat("t5a b3", 4'd7, 32'h5F5E5D5C, 4'hF, 2'b00, 1'b1, 2);

        // 5b: fill the command FIFO while R is stalled
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_cmd("t5b push", 4'(8 + k), 32'h60 + 32'(4 * k), 8'd0, 3'd2, 2'b01);
        end
        chk("t5b full cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("t5b full hold cmd_ready", 32'(cmd_ready), 32'd0);
        rready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            recv_beat("t5b drain", 4'(8 + k), exp_pat[k], 4'hF, 2'b00, 1'b1, (k == 0) ? -1 : 3);
        end
        chk("t5b drained cmd_ready", 32'(cmd_ready), 32'd1);

        // 6: reset in the middle of an 8-beat burst
        push_cmd("t6", 4'd13, 32'h80, 8'd7, 3'd2, 2'b01);
        recv_beat("t6 b0", 4'd13, 32'h83828180, 4'hF, 2'b00, 1'b0, -1);
        rready = 1'b0;
        seen = 0;
        while (!rvalid && seen < 60) begin
            @(posedge clk); #1; seen++;
        end
        chk("t6 b1 rdata", rdata, 32'h87868584);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6 rst rvalid", 32'(rvalid), 32'd0);
        chk("t6 rst rlast",  32'(rlast),  32'd0);
        chk("t6 rst rdata",  rdata,       32'd0);
        chk("t6 rst rstrb",  32'(rstrb),  32'd0);
        chk("t6 rst rresp",  32'(rresp),  32'd0);
        chk("t6 rst rid",    32'(rid),    32'd0);
        chk("t6 rst mem_ren", 32'(mem_ren), 32'd0);
        chk("t6 rst mem_addr", 32'(mem_addr), 32'd0);
        chk("t6 rst cmd_ready", 32'(cmd_ready), 32'd1);
        rready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (rvalid || rlast || mem_ren) seen++;
            @(posedge clk); #1;
        end
        chk("t6 idle after reset", 32'(seen), 32'd0);
        push_cmd("t6 post", 4'd14, 32'h90, 8'd1, 3'd2, 2'b01);
        recv_beat("t6 post b0", 4'd14, 32'h93929190, 4'hF, 2'b00, 1'b0, -1);
        recv_beat("t6 post b1", 4'd14, 32'h97969594, 4'hF, 2'b00, 1'b1, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
